// File: rtl/dap_usb_pkg.sv
// Shared definitions for the DAP USB packer/unpacker pair.
// Holds the packet-ring geometry, the ring alignment rule and the packet descriptor layout.
// No ports; imported by the interface users, the descriptor queue and the unpacker top.
package dap_usb_pkg;

  localparam int RAM_AW      = 12;
  localparam int RAM_BYTES   = 4096;
  localparam int ALIGN_SHIFT = 4;

  // Rounding constant for align16, sized to the 13-bit pre-wrap sum width.
  localparam logic [RAM_AW:0] ALIGN_ROUND = (RAM_AW+1)'((1 << ALIGN_SHIFT) - 1);

  typedef struct packed {
    logic [RAM_AW-1:0] start;
    logic [10:0]       len;
  } pkt_desc_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DROP = 2'd2
  } rx_state_e;

  // Round up to the next 16-byte boundary, wrapped into the ring.
  function automatic logic [RAM_AW-1:0] align16(input logic [RAM_AW:0] x);
    logic [RAM_AW:0] r;
    r = x + ALIGN_ROUND;
    r[ALIGN_SHIFT-1:0] = '0;
    return r[RAM_AW-1:0];
  endfunction

endpackage

// File: rtl/dap_usb_unpacker_if.sv
// USB SoftPHY receive bus plus the packet read port of the DAP OUT-endpoint unpacker.
// master: drives PHY receive signals and read/release requests (PHY + parser side).
// slave : the unpacker; returns ready, packet status, read data and drop count.
interface dap_usb_unpacker_if;
  logic [3:0]  usb_endpt;
  logic        usb_rxact;
  logic        usb_rxval;
  logic [7:0]  usb_rxdat;
  logic        usb_rxpktval;
  logic        usb_rxrdy;
  logic        pkt_valid;
  logic [10:0] pkt_len;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        pkt_release;
  logic [7:0]  drop_count;

  modport master (
    output usb_endpt, usb_rxact, usb_rxval, usb_rxdat, usb_rxpktval,
    output rd_en, rd_addr, pkt_release,
    input  usb_rxrdy, pkt_valid, pkt_len, rd_data, drop_count
  );

  modport slave (
    input  usb_endpt, usb_rxact, usb_rxval, usb_rxdat, usb_rxpktval,
    input  rd_en, rd_addr, pkt_release,
    output usb_rxrdy, pkt_valid, pkt_len, rd_data, drop_count
  );
endinterface

// File: rtl/dap_pkt_desc_fifo.sv
// Shift-register packet descriptor queue; head is always entry 0.
// Latency: push/pop take effect on the next clock; head/size are registered.
// Backpressure: push while full (without a pop) is dropped, pop while empty is ignored.
// Ports: clk/resetn; push + push_desc; pop; head (oldest entry); size (occupancy).
module dap_pkt_desc_fifo
  import dap_usb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  pkt_desc_t     push_desc,
  input  logic          pop,
  output pkt_desc_t     head,
  output logic [SW-1:0] size
);

  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
  localparam logic [SW-1:0] ONE_W   = SW'(1);

  pkt_desc_t       mem_q [DEPTH];
  pkt_desc_t       mem_d [DEPTH];
  logic [SW-1:0]   size_q, size_d;
  logic [SW-1:0]   push_idx;
  logic            do_pop, do_push;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    size_d   = size_q;
    do_pop   = pop && (size_q != '0);
    do_push  = push && ((size_q < DEPTH_W) || do_pop);
    push_idx = do_pop ? (size_q - ONE_W) : size_q;

    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      // Vacated tail slot is cleared so stale descriptors never resurface.
      mem_d[DEPTH-1] = '0;
    end

    // Index via compare so the size-width counter never drives an array select.
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(push_idx)) mem_d[i] = push_desc;
      end
    end

    if (do_push && !do_pop)      size_d = size_q + ONE_W;
    else if (do_pop && !do_push) size_d = size_q - ONE_W;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      size_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      size_q <= size_d;
    end
  end

  assign head = mem_q[0];
  assign size = size_q;

endmodule

// File: rtl/dap_usb_unpacker.sv
// DAP OUT-endpoint unpacker: buffers CRC-good host packets in a 4 KiB ring, exposes oldest for random reads.
// Latency: a packet becomes visible the cycle after usb_rxact falls; rd_data returns one cycle after rd_en.
// Backpressure: usb_rxrdy drops (PHY NAKs) when the descriptor queue is full or ring space < MAX_PKT_LEN.
// Ports: clk, resetn (async active-low), bus (slave modport: PHY receive side + packet read/release port).
module dap_usb_unpacker
  import dap_usb_pkg::*;
#(
  parameter logic [3:0] P_ENDPOINT     = 4'd1,
  parameter int         MAX_PACKET_NUM = 8,
  parameter int         MAX_PKT_LEN    = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  dap_usb_unpacker_if.slave    bus
);

  localparam int                QSW       = $clog2(MAX_PACKET_NUM + 1);
  localparam logic [QSW-1:0]    QMAX      = QSW'(MAX_PACKET_NUM);
  localparam logic [10:0]       MAX_LEN11 = 11'(MAX_PKT_LEN);
  localparam logic [RAM_AW:0]   MIN_FREE  = (RAM_AW+1)'(MAX_PKT_LEN);
  localparam logic [RAM_AW:0]   RING_SIZE = (RAM_AW+1)'(RAM_BYTES);

  rx_state_e          state_q, state_d;
  logic [RAM_AW-1:0]  wr_head_q, wr_head_d;
  logic [10:0]        wr_off_q, wr_off_d;
  logic               pktval_seen_q, pktval_seen_d;
  logic               ovf_q, ovf_d;
  logic [RAM_AW:0]    used_bytes_q, used_bytes_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic [7:0]         rd_data_q;

  logic [7:0]         ram [RAM_BYTES];

  logic               ep_sel, rx_active, can_accept;
  logic               commit, drop_inc, pop;
  logic               ram_we;
  logic [RAM_AW-1:0]  ram_waddr, rd_ptr;
  logic [RAM_AW:0]    free_bytes, add_bytes, sub_bytes;
  logic [QSW-1:0]     q_size;
  pkt_desc_t          head_desc, push_desc;

  assign ep_sel     = (bus.usb_endpt == P_ENDPOINT);
  // Endpoint switching away mid-transaction looks exactly like usb_rxact falling.
  assign rx_active  = ep_sel && bus.usb_rxact;
  assign free_bytes = RING_SIZE - used_bytes_q;
  assign can_accept = (q_size < QMAX) && (free_bytes >= MIN_FREE);
  assign pop        = bus.pkt_release && (q_size != '0);
  assign ram_waddr  = wr_head_q + {1'b0, wr_off_q};
  assign push_desc  = '{start: wr_head_q, len: wr_off_q};

  always_comb begin
    state_d       = state_q;
    wr_head_d     = wr_head_q;
    wr_off_d      = wr_off_q;
    pktval_seen_d = pktval_seen_q;
    ovf_d         = ovf_q;
    drop_count_d  = drop_count_q;
    commit        = 1'b0;
    drop_inc      = 1'b0;
    ram_we        = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (rx_active) begin
          if (can_accept) begin
            state_d       = RX_RECV;
            wr_off_d      = '0;
            pktval_seen_d = 1'b0;
            ovf_d         = 1'b0;
          end else begin
            state_d = RX_DROP;
          end
        end
      end
      RX_RECV: begin
        if (!rx_active) begin
          state_d = RX_IDLE;
          if (pktval_seen_q && !ovf_q && (wr_off_q != '0)) commit = 1'b1;
          else                                              drop_inc = 1'b1;
        end else begin
          if (bus.usb_rxval) begin
            // Bytes past MAX_PKT_LEN are not stored; the packet is poisoned instead.
            if (wr_off_q < MAX_LEN11) begin
              ram_we   = 1'b1;
              wr_off_d = wr_off_q + 11'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (bus.usb_rxpktval) pktval_seen_d = 1'b1;
        end
      end
      RX_DROP: begin
        if (!rx_active) begin
          state_d  = RX_IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Next packet starts on a 16-byte boundary; a dropped packet leaves the head in place.
    if (commit) wr_head_d = align16({1'b0, wr_head_q} + {2'b0, wr_off_q});
    if (drop_inc && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

    add_bytes    = commit ? {1'b0, align16({2'b0, wr_off_q})} : '0;
    sub_bytes    = pop ? {1'b0, align16({2'b0, head_desc.len})} : '0;
    used_bytes_d = used_bytes_q + add_bytes - sub_bytes;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RX_IDLE;
      wr_head_q     <= '0;
      wr_off_q      <= '0;
      pktval_seen_q <= 1'b0;
      ovf_q         <= 1'b0;
      used_bytes_q  <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_head_q     <= wr_head_d;
      wr_off_q      <= wr_off_d;
      pktval_seen_q <= pktval_seen_d;
      ovf_q         <= ovf_d;
      used_bytes_q  <= used_bytes_d;
      drop_count_q  <= drop_count_d;
    end
  end

  dap_pkt_desc_fifo #(
    .DEPTH (MAX_PACKET_NUM),
    .SW    (QSW)
  ) u_desc_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (commit),
    .push_desc (push_desc),
    .pop       (pop),
    .head      (head_desc),
    .size      (q_size)
  );

  // Packet RAM: no reset, contents only become meaningful through a committed descriptor.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= bus.usb_rxdat;
  end

  assign rd_ptr = head_desc.start + {2'b0, bus.rd_addr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        rd_data_q <= '0;
    else if (bus.rd_en) rd_data_q <= ram[rd_ptr];
  end

  assign bus.usb_rxrdy  = ep_sel && can_accept;
  assign bus.pkt_valid  = (q_size != '0);
  assign bus.pkt_len    = (q_size != '0) ? head_desc.len : 11'd0;
  assign bus.rd_data    = rd_data_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_dap_usb_unpacker.sv
// Directed-plus-random bench for the DAP OUT-endpoint unpacker.
// Reference: queued packets kept as a flat byte list plus a length list; ring usage from rounding rules.
// Ports: drives the master side of the bus interface, clk and resetn.
module tb_dap_usb_unpacker;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dap_usb_unpacker_if bus();

  dap_usb_unpacker dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] m_bytes [$];
  int         m_len   [$];
  int         m_used  = 0;
  int         m_head  = 0;
  int         m_drop  = 0;

  function automatic int al16(input int x);
    return (((x + 15) / 16) * 16) % 4096;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_pop();
    int n;
    if (m_len.size() != 0) begin
      n = m_len.pop_front();
      m_used -= al16(n);
      for (int k = 0; k < n; k++) void'(m_bytes.pop_front());
    end
  endtask

  task automatic release_head();
    bus.pkt_release = 1'b1;
    tick();
    bus.pkt_release = 1'b0;
    m_pop();
  endtask

  task automatic rd_check(input int addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr[9:0];
    tick();
    bus.rd_en = 1'b0;
    chk("rd_data", {24'd0, bus.rd_data}, {24'd0, m_bytes[addr]});
  endtask

  // Compares head status and ring usage, then reads back nread bytes (all bytes when all=1).
  task automatic check_head(input int nread, input bit all);
    int n;
    chk("pkt_valid", {31'd0, bus.pkt_valid}, (m_len.size() != 0) ? 1 : 0);
    chk("pkt_len", {21'd0, bus.pkt_len}, (m_len.size() != 0) ? m_len[0] : 0);
    chk("used_bytes", {19'd0, dut.used_bytes_q}, m_used);
    chk("drop_count", {24'd0, bus.drop_count}, m_drop);
    if (m_len.size() != 0) begin
      n = all ? m_len[0] : nread;
      for (int k = 0; k < n; k++) rd_check(all ? k : $urandom_range(0, m_len[0] - 1));
    end
  endtask

  // One OUT transaction. good: pulse rxpktval on the last byte. pat: bytes 0,1,2.. else random.
  // rel: assert pkt_release on the same cycle the transaction ends.
  task automatic send_pkt(input int ep, input int len, input bit good, input bit pat, input bit rel);
    logic [7:0] d [$];
    bit acc;
    acc = (ep == 1) && (m_len.size() < 8) && ((4096 - m_used) >= 1024);
    bus.usb_endpt = ep[3:0];
    bus.usb_rxact = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.usb_rxval    = 1'b0;
        bus.usb_rxpktval = 1'b0;
        tick();
      end
      bus.usb_rxval    = 1'b1;
      bus.usb_rxdat    = pat ? i[7:0] : 8'($urandom);
      bus.usb_rxpktval = good && (i == len - 1);
      d.push_back(bus.usb_rxdat);
      tick();
    end
    if (len == 0 && good) begin
      bus.usb_rxval    = 1'b0;
      bus.usb_rxpktval = 1'b1;
      tick();
    end
    bus.usb_rxval    = 1'b0;
    bus.usb_rxpktval = 1'b0;
    bus.usb_rxact    = 1'b0;
    bus.pkt_release  = rel;
    tick();
    bus.pkt_release = 1'b0;
    if (rel) m_pop();
    if (acc && good && len > 0 && len <= 1024) begin
      m_len.push_back(len);
      foreach (d[k]) m_bytes.push_back(d[k]);
      m_used += al16(len);
      m_head = (m_head + al16(len)) % 4096;
    end else if (ep == 1 && m_drop < 255) begin
      m_drop++;
    end
    bus.usb_endpt = 4'd1;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int rem;
    int n;
    logic [7:0] held;

    resetn           = 1'b0;
    bus.usb_endpt    = 4'd0;
    bus.usb_rxact    = 1'b0;
    bus.usb_rxval    = 1'b0;
    bus.usb_rxdat    = 8'd0;
    bus.usb_rxpktval = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = 10'd0;
    bus.pkt_release  = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("rst_pkt_valid", {31'd0, bus.pkt_valid}, 0);
    chk("rst_pkt_len", {21'd0, bus.pkt_len}, 0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 0);
    chk("rst_drop_count", {24'd0, bus.drop_count}, 0);
    chk("rst_rxrdy_ep0", {31'd0, bus.usb_rxrdy}, 0);
    bus.usb_endpt = 4'd1;
    #1;
    chk("rst_rxrdy_ep1", {31'd0, bus.usb_rxrdy}, 1);
    resetn = 1'b1;
    tick();

    // 64-byte counting packet, byte 5 readback, then read-data hold.
    send_pkt(1, 64, 1, 1, 0);
    chk("p64_len", {21'd0, bus.pkt_len}, 64);
    rd_check(5);
    chk("p64_byte5", {24'd0, bus.rd_data}, 8'h05);
    held        = bus.rd_data;
    bus.rd_addr = 10'd9;
    tick();
    chk("rd_hold", {24'd0, bus.rd_data}, {24'd0, held});
    check_head(8, 0);
    release_head();
    check_head(0, 0);

    // 13 then 20 bytes: second packet starts on the next 16-byte boundary.
    send_pkt(1, 13, 1, 0, 0);
    chk("wr_head_after13", {20'd0, dut.wr_head_q}, m_head);
    send_pkt(1, 20, 1, 0, 0);
    chk("used_13_20", {19'd0, dut.used_bytes_q}, m_used);
    check_head(13, 1);
    release_head();
    check_head(20, 1);
    release_head();

    // Missing CRC strobe: dropped, head pointer unmoved, next packet reuses the slot.
    send_pkt(1, 30, 0, 0, 0);
    chk("nocrc_wr_head", {20'd0, dut.wr_head_q}, m_head);
    check_head(0, 0);
    send_pkt(1, 10, 1, 0, 0);
    check_head(10, 1);
    release_head();

    // Oversize and zero-length packets are dropped.
    send_pkt(1, 1025, 1, 0, 0);
    check_head(0, 0);
    send_pkt(1, 0, 1, 0, 0);
    check_head(0, 0);

    // Foreign endpoint: not ready, not counted.
    bus.usb_endpt = 4'd2;
    #1;
    chk("ep2_rxrdy", {31'd0, bus.usb_rxrdy}, 0);
    send_pkt(2, 16, 1, 0, 0);
    check_head(0, 0);

    // Fill the descriptor queue.
    for (int p = 0; p < 8; p++) send_pkt(1, $urandom_range(1, 64), 1, 0, 0);
    chk("full_q_size", {28'd0, dut.q_size}, 8);
    chk("full_rxrdy", {31'd0, bus.usb_rxrdy}, 0);
    send_pkt(1, 12, 1, 0, 0);
    check_head(4, 0);
    release_head();
    chk("after_rel_rxrdy", {31'd0, bus.usb_rxrdy}, 1);
    while (m_len.size() != 0) begin
      check_head(4, 0);
      release_head();
    end
    check_head(0, 0);

    // Walk the write head up to 4080 so the next packet wraps the ring.
    while (m_head != 4080) begin
      rem = (4080 - m_head + 4096) % 4096;
      n   = (rem > 1024) ? 1024 : rem;
      send_pkt(1, n, 1, 0, 0);
      check_head(3, 0);
      release_head();
    end
    chk("wrap_wr_head", {20'd0, dut.wr_head_q}, 4080);
    send_pkt(1, 40, 1, 0, 0);
    check_head(40, 1);

    // Commit and release in the same cycle keep the queue depth constant.
    send_pkt(1, 24, 1, 0, 1);
    chk("simul_q_size", {28'd0, dut.q_size}, 1);
    check_head(24, 1);
    release_head();
    check_head(0, 0);

    // Reset in the middle of a packet with one packet already queued.
    send_pkt(1, 18, 1, 0, 0);
    bus.usb_rxact = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.usb_rxval = 1'b1;
      bus.usb_rxdat = 8'($urandom);
      tick();
    end
    resetn        = 1'b0;
    bus.usb_rxval = 1'b0;
    bus.usb_rxact = 1'b0;
    m_len.delete();
    m_bytes.delete();
    m_used = 0;
    m_head = 0;
    m_drop = 0;
    tick();
    check_head(0, 0);
    chk("rst_mid_wr_head", {20'd0, dut.wr_head_q}, 0);
    resetn = 1'b1;
    tick();
    send_pkt(1, 7, 1, 0, 0);
    check_head(7, 1);
    release_head();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
